// File: rtl/quad_gen_pkg.sv
// rtl/quad_gen_pkg.sv - shared types and phase helpers for the quadrature encoder emulator
package quad_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] PHASE_FWD = 2'd1;
    localparam logic [1:0] PHASE_REV = 2'd3;

    // Gray sequence: consecutive phases differ in exactly one of A/B
    function automatic logic [1:0] phase_to_ab(input logic [1:0] phase);
        logic [1:0] ab;
        case (phase)
            2'd0:    ab = 2'b00;
            2'd1:    ab = 2'b10;
            2'd2:    ab = 2'b11;
            default: ab = 2'b01;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/quad_tick_div.sv
// rtl/quad_tick_div.sv - loadable auto-reloading down-counter that ticks at zero
module quad_tick_div #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tick
);

    logic [W-1:0] cnt;
    logic [W-1:0] reload;

    assign tick = en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            reload <= '0;
        end else if (load) begin
            cnt    <= load_val;
            reload <= load_val;
        end else if (en) begin
            if (cnt == '0)
                cnt <= reload;
            else
                cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/quad_encoder_gen.sv
// rtl/quad_encoder_gen.sv - quadrature A/B/Z generator driven by signed step commands
module quad_encoder_gen
    import quad_gen_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int PERIOD_W = 16,
    parameter int PPR      = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CNT_W-1:0]    cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                abort,
    output logic                A,
    output logic                B,
    output logic                Z,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    position
);

    localparam int ANG_W = $clog2(PPR);
    localparam logic [ANG_W-1:0] ANG_MAX = ANG_W'(PPR - 1);

    state_t              state;
    state_t              state_next;
    logic                dir;
    logic [CNT_W-1:0]    remaining;
    logic [1:0]          phase;
    logic [1:0]          phase_next;
    logic [ANG_W-1:0]    angle;
    logic [ANG_W-1:0]    angle_next;
    logic [CNT_W-1:0]    steps_abs;
    logic [PERIOD_W-1:0] div_load;
    logic                accept;
    logic                start;
    logic                edge_tick;
    logic                last_edge;

    assign accept    = cmd_valid && cmd_ready;
    assign start     = accept && (cmd_steps != '0);
    assign last_edge = edge_tick && (remaining == CNT_W'(1));

    // Two's-complement negate makes the most-negative command map to 2^(CNT_W-1)
    assign steps_abs = cmd_steps[CNT_W-1] ? (~cmd_steps + CNT_W'(1)) : cmd_steps;
    assign div_load  = (cmd_period == '0) ? '0 : (cmd_period - PERIOD_W'(1));

    quad_tick_div #(
        .W(PERIOD_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .load_val (div_load),
        .en       (busy && !abort),
        .tick     (edge_tick)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !abort;
                if (cmd_valid && !abort && (cmd_steps != '0))
                    state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (abort || last_edge)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign phase_next = phase + (dir ? PHASE_REV : PHASE_FWD);

    always_comb begin
        angle_next = angle;
        if (dir)
            angle_next = (angle == '0) ? ANG_MAX : (angle - ANG_W'(1));
        else
            angle_next = (angle == ANG_MAX) ? '0 : (angle + ANG_W'(1));
    end

    // A/B/Z all load from the same post-edge values so the index never skews
    always_ff @(posedge clk) begin
        if (reset) begin
            A         <= 1'b0;
            B         <= 1'b0;
            Z         <= 1'b1;
            done      <= 1'b0;
            dir       <= 1'b0;
            remaining <= '0;
            phase     <= 2'd0;
            angle     <= '0;
            position  <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (cmd_steps == '0) begin
                    done <= 1'b1;
                end else begin
                    dir       <= cmd_steps[CNT_W-1];
                    remaining <= steps_abs;
                end
            end
            if (edge_tick) begin
                phase     <= phase_next;
                {A, B}    <= phase_to_ab(phase_next);
                angle     <= angle_next;
                Z         <= (angle_next == '0);
                position  <= dir ? (position - CNT_W'(1)) : (position + CNT_W'(1));
                remaining <= remaining - CNT_W'(1);
                if (last_edge)
                    done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// tb/tb_quad_encoder_gen.sv - scoreboard bench for quad_encoder_gen with a position-based reference model
module tb_quad_encoder_gen;

    localparam int TB_PPR = 4;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_steps;
    logic [15:0] cmd_period;
    logic        abort;
    logic        A;
    logic        B;
    logic        Z;
    logic        busy;
    logic        done;
    logic [31:0] position;

    quad_encoder_gen #(
        .CNT_W    (32),
        .PERIOD_W (16),
        .PPR      (TB_PPR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .A          (A),
        .B          (B),
        .Z          (Z),
        .busy       (busy),
        .done       (done),
        .position   (position)
    );

    typedef struct {
        bit          is_done;
        longint      cyc;
        logic [1:0]  ab;
        logic        z;
        logic [31:0] pos;
    } ev_t;

    ev_t    exp_q[$];
    longint cyc = 0;
    longint model_pos;
    int     vectors = 0;
    int     miscompares = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [1:0] model_ab(input longint pos);
        longint ph;
        ph = ((pos % 4) + 4) % 4;
        case (ph)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    // Every edge moves position by one, so phase and angle are just position modulo 4 / PPR
    function automatic longint model_cmd(input longint acc, input int steps, input int period, input int n_edges);
        longint p;
        longint n;
        longint lim;
        ev_t    e;
        p   = (period == 0) ? 1 : period;
        n   = (steps < 0) ? -steps : steps;
        lim = (n_edges < 0) ? n : n_edges;
        for (longint k = 1; k <= lim; k++) begin
            model_pos += (steps < 0) ? -1 : 1;
            e.is_done = 1'b0;
            e.cyc     = acc + k * p;
            e.ab      = model_ab(model_pos);
            e.z       = ((((model_pos % TB_PPR) + TB_PPR) % TB_PPR) == 0);
            e.pos     = 32'(model_pos);
            exp_q.push_back(e);
        end
        if (n_edges >= 0)
            return -1;
        e.is_done = 1'b1;
        e.cyc     = (n == 0) ? acc : acc + n * p;
        e.ab      = model_ab(model_pos);
        e.z       = ((((model_pos % TB_PPR) + TB_PPR) % TB_PPR) == 0);
        e.pos     = 32'(model_pos);
        exp_q.push_back(e);
        return e.cyc;
    endfunction

    initial begin
        logic [1:0] prev_ab;
        ev_t        e;
        prev_ab = 2'b00;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                prev_ab = {A, B};
            end else begin
                if ({A, B} !== prev_ab) begin
                    if (exp_q.size() == 0 || exp_q[0].is_done) begin
                        check("unexpected_edge", 64'({A, B}), 64'(prev_ab));
                    end else begin
                        e = exp_q.pop_front();
                        check("edge_cycle", 64'(cyc), 64'(e.cyc));
                        check("edge_ab", 64'({A, B}), 64'(e.ab));
                        check("edge_z", 64'(Z), 64'(e.z));
                        check("edge_pos", 64'(position), 64'(e.pos));
                    end
                    prev_ab = {A, B};
                end
                if (done) begin
                    if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                        check("unexpected_done", 64'(done), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("done_cycle", 64'(cyc), 64'(e.cyc));
                        check("done_pos", 64'(position), 64'(e.pos));
                        check("done_busy", 64'(busy), 64'(0));
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        model_pos = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_ab", 64'({A, B}), 64'(0));
        check("rst_z", 64'(Z), 64'(1));
        check("rst_pos", 64'(position), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ready", 64'(cmd_ready), 64'(1));
    endtask

    task automatic send(input int steps, input int period, input int abort_after,
                        output longint acc, output longint done_cyc);
        int     waited;
        longint p;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_steps  = steps;
        cmd_period = 16'(period);
        waited     = 0;
        #1;
        while (!cmd_ready && waited < 2000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!cmd_ready)
            check("accept_timeout", 64'(cmd_ready), 64'(1));
        acc      = cyc + 1;
        done_cyc = model_cmd(acc, steps, period, abort_after);
        @(negedge clk);
        cmd_valid  = 1'b0;
        cmd_steps  = $urandom;
        cmd_period = 16'($urandom);
        if (abort_after >= 0) begin
            p = (period == 0) ? 1 : period;
            while (cyc < acc + (abort_after + 1) * p - 1)
                @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || busy)
            check("idle_timeout", 64'(exp_q.size()), 64'(0));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        longint acc1;
        longint acc2;
        longint dn1;
        longint dn2;
        int     st;
        int     per;

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
        abort      = 1'b0;
        model_pos  = 0;

        do_reset();
        send(8, 4, -1, acc1, dn1);
        wait_idle();
        check("fwd_pos", 64'(position), 64'(32'd8));

        do_reset();
        send(-5, 1, -1, acc1, dn1);
        wait_idle();
        check("rev_pos", 64'(position), 64'(32'hFFFF_FFFB));

        send(0, 7, -1, acc1, dn1);
        wait_idle();
        send(3, 0, -1, acc1, dn1);
        wait_idle();

        send(100, 10, 20, acc1, dn1);
        repeat (30) @(negedge clk);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_pos", 64'(position), 64'(32'(model_pos)));
        wait_idle();

        @(negedge clk);
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_steps = 32'd5;
        repeat (4) begin
            #1;
            check("abort_idle_ready", 64'(cmd_ready), 64'(0));
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_idle_busy", 64'(busy), 64'(0));

        send(6, 2, -1, acc1, dn1);
        send(-4, 3, -1, acc2, dn2);
        check("b2b_accept", 64'(acc2), 64'(dn1 + 1));
        wait_idle();

        for (int i = 0; i < 10; i++) begin
            st  = int'($urandom_range(0, 24)) - 12;
            per = int'($urandom_range(0, 5));
            send(st, per, -1, acc1, dn1);
            if ($urandom_range(0, 1) == 1)
                wait_idle();
        end
        wait_idle();

        send(50, 3, -1, acc1, dn1);
        repeat (20) @(negedge clk);
        do_reset();
        repeat (10) @(negedge clk);
        check("post_reset_q", 64'(exp_q.size()), 64'(0));

        repeat (10) @(negedge clk);
        check("final_queue", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
